// File: rtl/regbank8_issue_pkg.sv
// Shared definitions for the eight-entry register bank with read-issue handshake.
package regbank8_issue_pkg;

  localparam int unsigned NREGS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/regbank8_issue_scoreboard8.sv
// Busy scoreboard: per-register reservation bits plus the "clear to read" lookups
// for the incoming read address and the held (stalled) address.
module regbank8_issue_scoreboard8
  import regbank8_issue_pkg::*;
#(
  parameter int unsigned selwidth = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [selwidth-1:0] wr_addr,
  input  logic                rsv_en,
  input  logic [selwidth-1:0] rsv_addr,
  input  logic [selwidth-1:0] rd_addr,
  input  logic [selwidth-1:0] hold_addr,
  output logic [NREGS-1:0]    busy,
  output logic                rd_clr,
  output logic                hold_clr
);

  // A reservation landing in the same cycle as the completing write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (rsv_en && (rsv_addr == selwidth'(i)))
          busy[i] <= 1'b1;
        else if (wr_en && (wr_addr == selwidth'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  // Uses the pre-edge busy vector, so a same-cycle reservation never blocks the read.
  always_comb begin
    rd_clr   = ~busy[rd_addr]   | (wr_en & (wr_addr == rd_addr));
    hold_clr = ~busy[hold_addr] | (wr_en & (wr_addr == hold_addr));
  end

endmodule

// File: rtl/regbank8_issue.sv
// Eight-entry register bank feeding an 8:1 bus mux, with a busy scoreboard that
// stalls reads of pending registers and a one-cycle issue pulse per read.
module regbank8_issue
  import regbank8_issue_pkg::*;
#(
  parameter int unsigned buswidth = 32,
  parameter int unsigned selwidth = 3
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_wr_en,
  input  logic [selwidth-1:0] in_wr_addr,
  input  logic [buswidth-1:0] in_wr_data,
  input  logic                in_rsv_en,
  input  logic [selwidth-1:0] in_rsv_addr,
  input  logic                in_rd_valid,
  input  logic [selwidth-1:0] in_rd_addr,
  output logic                out_rd_ready,
  output logic [selwidth-1:0] out_select,
  output logic                out_sel_valid,
  output logic [buswidth-1:0] out_reg0,
  output logic [buswidth-1:0] out_reg1,
  output logic [buswidth-1:0] out_reg2,
  output logic [buswidth-1:0] out_reg3,
  output logic [buswidth-1:0] out_reg4,
  output logic [buswidth-1:0] out_reg5,
  output logic [buswidth-1:0] out_reg6,
  output logic [buswidth-1:0] out_reg7,
  output logic [NREGS-1:0]    out_busy,
  output logic [7:0]          out_stall_cnt
);

  state_t                state;
  logic [selwidth-1:0]   hold;
  logic [buswidth-1:0]   regs [NREGS];
  logic                  rd_clr;
  logic                  hold_clr;

  regbank8_issue_scoreboard8 #(
    .selwidth(selwidth)
  ) u_scoreboard (
    .clk      (in_clk),
    .rst      (in_reset),
    .wr_en    (in_wr_en),
    .wr_addr  (in_wr_addr),
    .rsv_en   (in_rsv_en),
    .rsv_addr (in_rsv_addr),
    .rd_addr  (in_rd_addr),
    .hold_addr(hold),
    .busy     (out_busy),
    .rd_clr   (rd_clr),
    .hold_clr (hold_clr)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (in_wr_en) begin
      regs[in_wr_addr] <= in_wr_data;
    end
  end

  assign out_reg0 = regs[0];
  assign out_reg1 = regs[1];
  assign out_reg2 = regs[2];
  assign out_reg3 = regs[3];
  assign out_reg4 = regs[4];
  assign out_reg5 = regs[5];
  assign out_reg6 = regs[6];
  assign out_reg7 = regs[7];

  assign out_rd_ready = (state != WAIT);

  // Issue outputs are loaded on the transition into ISSUE so they are registered
  // and valid for exactly the ISSUE cycle.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state         <= IDLE;
      hold          <= '0;
      out_select    <= '0;
      out_sel_valid <= 1'b0;
      out_stall_cnt <= '0;
    end else begin
      out_sel_valid <= 1'b0;
      case (state)
        WAIT: begin
          if (out_stall_cnt != '1)
            out_stall_cnt <= out_stall_cnt + 8'd1;
          if (hold_clr) begin
            state         <= ISSUE;
            out_sel_valid <= 1'b1;
            out_select    <= hold;
          end
        end
        IDLE, ISSUE: begin
          if (in_rd_valid) begin
            hold <= in_rd_addr;
            if (rd_clr) begin
              state         <= ISSUE;
              out_sel_valid <= 1'b1;
              out_select    <= in_rd_addr;
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank8_issue.sv
// Randomized scoreboard bench for regbank8_issue with directed corner sequences.
module tb_regbank8_issue;

  logic        clk = 1'b0;
  logic        in_reset = 1'b0;
  logic        in_wr_en = 1'b0;
  logic [2:0]  in_wr_addr = '0;
  logic [31:0] in_wr_data = '0;
  logic        in_rsv_en = 1'b0;
  logic [2:0]  in_rsv_addr = '0;
  logic        in_rd_valid = 1'b0;
  logic [2:0]  in_rd_addr = '0;
  logic        out_rd_ready;
  logic [2:0]  out_select;
  logic        out_sel_valid;
  logic [31:0] dreg [8];
  logic [7:0]  out_busy;
  logic [7:0]  out_stall_cnt;

  always #5 clk = ~clk;

  regbank8_issue #(.buswidth(32), .selwidth(3)) dut (
    .in_clk(clk), .in_reset(in_reset),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .in_rsv_en(in_rsv_en), .in_rsv_addr(in_rsv_addr),
    .in_rd_valid(in_rd_valid), .in_rd_addr(in_rd_addr),
    .out_rd_ready(out_rd_ready), .out_select(out_select), .out_sel_valid(out_sel_valid),
    .out_reg0(dreg[0]), .out_reg1(dreg[1]), .out_reg2(dreg[2]), .out_reg3(dreg[3]),
    .out_reg4(dreg[4]), .out_reg5(dreg[5]), .out_reg6(dreg[6]), .out_reg7(dreg[7]),
    .out_busy(out_busy), .out_stall_cnt(out_stall_cnt)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [2:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  // Reference model: register file, reservation set, one blocked read at most.
  logic [31:0] m_reg [8];
  bit          m_busy [8];
  bit          m_wait;
  logic [2:0]  m_wait_addr;
  int          m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_clear(input logic [2:0] a, input bit we, input logic [2:0] wa);
    return !m_busy[a] || (we && wa == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 0;
    end
    m_wait = 0;
    m_wait_addr = '0;
    m_stall = 0;
    expq.delete();
  endtask

  task automatic check_state();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = m_busy[i];
    chk("rd_ready", out_rd_ready, !m_wait);
    chk("busy", out_busy, b);
    chk("stall_cnt", out_stall_cnt, m_stall);
    for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), dreg[i], m_reg[i]);
  endtask

  // Applies one cycle of stimulus, advances the model, then samples at the next negedge.
  task automatic cycle(input bit we, input logic [2:0] wa, input logic [31:0] wd,
                       input bit re, input logic [2:0] ra,
                       input bit qe, input logic [2:0] qa);
    bit         push;
    logic [2:0] pa;
    in_wr_en = we; in_wr_addr = wa; in_wr_data = wd;
    in_rsv_en = re; in_rsv_addr = ra;
    in_rd_valid = qe; in_rd_addr = qa;
    push = 0;
    pa = '0;
    if (m_wait) begin
      if (m_stall < 255) m_stall++;
      if (m_clear(m_wait_addr, we, wa)) begin
        push = 1;
        pa = m_wait_addr;
        m_wait = 0;
      end
    end else if (qe) begin
      if (m_clear(qa, we, wa)) begin
        push = 1;
        pa = qa;
      end else begin
        m_wait = 1;
        m_wait_addr = qa;
      end
    end
    if (we) begin
      m_reg[wa] = wd;
      m_busy[wa] = 0;
    end
    if (re) m_busy[ra] = 1;
    if (push) expq.push_back('{due: cyc + 1, addr: pa, data: m_reg[pa]});
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    cycle(0, 3'd0, 32'd0, 0, 3'd0, 0, 3'd0);
  endtask

  task automatic do_reset();
    #2;
    in_wr_en = 0; in_rsv_en = 0; in_rd_valid = 0;
    in_reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reset_reg%0d", i), dreg[i], 32'd0);
    chk("reset_busy", out_busy, 8'h00);
    chk("reset_sel_valid", out_sel_valid, 1'b0);
    chk("reset_rd_ready", out_rd_ready, 1'b1);
    chk("reset_stall_cnt", out_stall_cnt, 8'd0);
    chk("reset_select", out_select, 3'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 in_reset = 1'b0;
  endtask

  // Monitor: every issue pulse must match the oldest expected issue due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL issue_missing: no pulse for addr %0d, expected at cycle %0d", expq[0].addr, expq[0].due);
        void'(expq.pop_front());
      end
      if (out_sel_valid === 1'b1) begin
        if (expq.size() == 0 || expq[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: sel_valid 1 select %0d, expected no issue (cycle %0d)", out_select, cyc);
        end else begin
          e = expq.pop_front();
          chk("issue_select", out_select, e.addr);
          chk("issue_data", dreg[e.addr], e.data);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Unstalled read
    cycle(1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 0, 3'd0);
    cycle(0, 3'd0, 32'd0, 0, 3'd0, 1, 3'd3);
    chk("unstalled_valid", out_sel_valid, 1'b1);
    chk("unstalled_select", out_select, 3'd3);
    chk("unstalled_data", dreg[3], 32'hDEADBEEF);

    // Stall and release
    cycle(0, 3'd0, 32'd0, 1, 3'd5, 0, 3'd0);
    cycle(0, 3'd0, 32'd0, 0, 3'd0, 1, 3'd5);
    chk("stall_ready_low", out_rd_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("stall_no_issue", out_sel_valid, 1'b0);
    end
    cycle(1, 3'd5, 32'h1234, 0, 3'd0, 0, 3'd0);
    chk("release_valid", out_sel_valid, 1'b1);
    chk("release_select", out_select, 3'd5);
    chk("release_stall_cnt", out_stall_cnt, 8'd4);
    chk("release_busy5", out_busy[5], 1'b0);
    chk("release_data", dreg[5], 32'h1234);

    // Same-cycle reserve and write on r2, read of r2 in that cycle
    cycle(1, 3'd2, 32'hA5A5_0002, 1, 3'd2, 1, 3'd2);
    chk("setclr_busy2", out_busy[2], 1'b1);
    chk("setclr_valid", out_sel_valid, 1'b1);
    chk("setclr_select", out_select, 3'd2);
    idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 1) == 0, 3'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 6) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 4) < 3, 3'($urandom_range(0, 7)));
    end

    // Mid-run reset, then saturation and reset in WAIT
    do_reset();
    cycle(0, 3'd0, 32'd0, 1, 3'd6, 0, 3'd0);
    cycle(0, 3'd0, 32'd0, 0, 3'd0, 1, 3'd6);
    for (int i = 0; i < 300; i++) idle();
    chk("saturated_stall_cnt", out_stall_cnt, 8'd255);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("no_issue_after_wait_reset", out_sel_valid, 1'b0);
    end

    // Reset during ISSUE
    cycle(0, 3'd0, 32'd0, 0, 3'd0, 1, 3'd1);
    chk("pre_reset_issue", out_sel_valid, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("no_issue_after_issue_reset", out_sel_valid, 1'b0);
    end

    for (int i = 0; i < 4; i++) idle();
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
